traffic_conflict_monitor: RTL
=============================

Name: traffic_conflict_monitor

Overview:
- Independent safety monitor that sits on the receiving end of the 4-way intersection controller's light outputs (light_north/east/south/west, ped_walk).
- Checks every cycle for:
  - conflicting right-of-way,
  - illegal light encodings,
  - illegal sequencing (green to red without yellow, short yellow),
  - a stalled controller.
- On a fault, it latches a fault code and drives a flashing-red override request to the output stage.
- The fault is held until an operator clear is accepted.

Parameters:
- FILTER_CYCLES, 3: consecutive clk cycles a level violation must persist before it faults (glitch filter).
- MIN_YELLOW, 2: minimum tick pulses counted in yellow before a yellow-to-red transition is legal. A 3-tick yellow yields 2 or 3 counts, depending on alignment.
- WDOG_TICKS, 16: ticks without any change on the monitored inputs (while not all-red) before a stall fault.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  1-second enable pulse, one clk wide (same as controller's clk_enable)
- light_north  in  3  {R,Y,G} one-hot
- light_east  in  3  {R,Y,G} one-hot
- light_south  in  3  {R,Y,G} one-hot
- light_west  in  3  {R,Y,G} one-hot
- ped_walk  in  1  pedestrian walk indication
- fault_clr  in  1  level operator clear request
- fault  out  1  latched fault flag
- fault_code  out  3  0 none, 1 conflict, 2 ped conflict, 3 invalid encoding, 4 skipped yellow, 5 short yellow, 6 watchdog
- fault_dir  out  2  offending approach (N=0, E=1, S=2, W=3); 0 for codes 1, 2, 6
- flash_red  out  1  toggles on each tick while faulted; 0 otherwise

Behaviour:
- Reset:
  - fault, fault_code, fault_dir, flash_red = 0.
  - All counters = 0.
  - Per-approach previous-light registers = RED (100). The first green after reset is therefore legal.
- Encoding: RED=100, YELLOW=010, GREEN=001. Any other value is invalid.
- FSM has two states:
  - MONITOR: the reset state.
  - FAULT.
- Level violations (instantaneous, evaluated each cycle in MONITOR):
  - conflict: more than one approach non-RED.
  - ped conflict: ped_walk=1 while any approach non-RED.
  - invalid: any approach encoding invalid.
- Level violation filtering:
  - Each violation type has its own counter. The counter increments on each edge where the violation is true and clears to 0 on any edge where it is false.
  - When the counter is at FILTER_CYCLES-1 and the violation is still true, MONITOR goes to FAULT on that edge.
  - Result: fault rises FILTER_CYCLES edges after onset. A violation lasting FILTER_CYCLES-1 cycles is ignored.
- Transition violations (per approach; previous-light register updated every cycle in MONITOR):
  - skipped yellow: previous=GREEN and current=RED.
  - short yellow: previous=YELLOW, current=RED, and yellow count < MIN_YELLOW.
  - Both fault on the same edge they are seen, i.e. fault is visible 1 cycle after the offending input.
- Yellow counter (per approach):
  - Cleared on entry to YELLOW.
  - Increments on tick while YELLOW.
  - Saturates at MIN_YELLOW.
- YELLOW-to-GREEN and RED-to-YELLOW transitions are not checked.
- Watchdog:
  - Counts ticks.
  - Cleared on any cycle where any light vector or ped_walk differs from its previous sample.
  - Held at 0 while all four approaches are RED and ped_walk=0. This makes an emergency all-red hold of unlimited length legal.
  - Faults when the count reaches WDOG_TICKS.
- Simultaneous faults:
  - The lowest code wins.
  - Within a code, the lowest approach index wins.
- FAULT state:
  - All checking and counters are frozen.
  - fault_code and fault_dir are held.
  - flash_red inverts on each tick, starting from 0, so it first goes to 1 on the first tick after entry.
- Clear:
  - fault_clr in FAULT is accepted only on a cycle where all approaches are RED and ped_walk=0. Otherwise it is ignored, and holding the level keeps retrying.
  - On acceptance, on the next edge: MONITOR; fault, fault_code, fault_dir, flash_red = 0; all counters 0; previous registers loaded with the current inputs.
- fault_clr in MONITOR has no effect.
- rst_n assertion at any time, including in FAULT, returns everything to reset values immediately.

Decomposition:
- Shared package traffic_pkg, containing:
  - the light encodings RED/YELLOW/GREEN, shared with the controller;
  - the fault code constants;
  - the approach index constants.
- One sub-module, approach_seq_checker, instantiated 4x. It contains:
  - the previous-light register;
  - the yellow counter;
  - the invalid, skipped-yellow and short-yellow flags;
  - a freeze input and a load-current input, used for clear.
- The top level contains: conflict/ped logic, filter counters, watchdog, priority encoder, FSM and flash toggle.

Test Plan:
- Normal operation, tick every 4 clk: drive the controller's nominal sequence (green 10, yellow 3, ped 10 ticks) for 2 full rotations, then hold all-red for 100 ticks. Required: fault=0 throughout.
- Conflict filtering: N=GREEN and E=GREEN for 2 cycles, then back to legal. Required: no fault. Repeat for 3 cycles. Required: fault=1, code=1, dir=0 after the 3rd edge; flash_red toggles on each subsequent tick.
- Skipped and short yellow:
  - E goes GREEN then RED directly. Required: code=4, dir=1, one cycle later.
  - Separately, after reset, S is YELLOW for 1 tick then RED. Required: code=5, dir=2.
- Watchdog: W held at GREEN for 16 ticks with no change. Required: code=6 at the 16th tick.
- Simultaneous events:
  - ped_walk=1 with N=GREEN. Required: code=2 after 3 cycles.
  - N=011 (invalid) together with an E conflict. Required: code=1 wins over code 3.
- Clear and reset:
  - In FAULT, fault_clr=1 with N=GREEN. Required: fault stays 1.
  - Drive all-red. Required: fault=0, code=0, flash_red=0 on the next edge.
  - Separately, assert rst_n=0 mid-FAULT. Required: all outputs 0 immediately.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection controller and its safety monitor:
// light values, fault codes, approach indices and monitor states.
package traffic_pkg;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_CONFLICT = 3'd1;
   localparam logic [2:0] FC_PED      = 3'd2;
   localparam logic [2:0] FC_INVALID  = 3'd3;
   localparam logic [2:0] FC_SKIP_YEL = 3'd4;
   localparam logic [2:0] FC_SHORT_YEL = 3'd5;
   localparam logic [2:0] FC_WDOG     = 3'd6;

   localparam logic [1:0] DIR_N = 2'd0;
   localparam logic [1:0] DIR_E = 2'd1;
   localparam logic [1:0] DIR_S = 2'd2;
   localparam logic [1:0] DIR_W = 2'd3;

   typedef enum logic {
      MONITOR = 1'b0,
      FAULT   = 1'b1
   } mon_state_t;

   function automatic logic valid_light(input logic [2:0] l);
      return (l == RED) || (l == YELLOW) || (l == GREEN);
   endfunction

   // Lowest set approach index; callers only use it when v is non-zero.
   function automatic logic [1:0] low_idx(input logic [3:0] v);
      logic [1:0] r;
      if (v[0])      r = DIR_N;
      else if (v[1]) r = DIR_E;
      else if (v[2]) r = DIR_S;
      else           r = DIR_W;
      return r;
   endfunction

endpackage

// File: rtl/approach_seq_checker.sv
// Per-approach sequencing checker: remembers the previous light and
// counts yellow ticks to flag invalid codes, skipped and short yellows.
module approach_seq_checker
   import traffic_pkg::*;
#(
   parameter int MIN_YELLOW = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic [2:0] light,
   input  logic       freeze,
   input  logic       load,
   output logic       invalid,
   output logic       skip_yellow,
   output logic       short_yellow
);

   localparam int YW = $clog2(MIN_YELLOW + 1);

   logic [2:0]    prev;
   logic [YW-1:0] ycnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= RED;
         ycnt <= '0;
      end else if (load) begin
         prev <= light;
         ycnt <= '0;
      end else if (!freeze) begin
         prev <= light;
         if (light == YELLOW) begin
            if (prev != YELLOW)
               ycnt <= '0;
            else if (tick && ycnt != YW'(MIN_YELLOW))
               ycnt <= ycnt + 1'b1;
         end
      end
   end

   assign invalid      = !valid_light(light);
   assign skip_yellow  = (prev == GREEN) && (light == RED);
   assign short_yellow = (prev == YELLOW) && (light == RED)
                         && (ycnt < YW'(MIN_YELLOW));

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor on the intersection light outputs; latches
// the first fault seen and requests flashing red until cleared.
module traffic_conflict_monitor
   import traffic_pkg::*;
#(
   parameter int FILTER_CYCLES = 3,
   parameter int MIN_YELLOW    = 2,
   parameter int WDOG_TICKS    = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic [2:0] light_north,
   input  logic [2:0] light_east,
   input  logic [2:0] light_south,
   input  logic [2:0] light_west,
   input  logic       ped_walk,
   input  logic       fault_clr,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [1:0] fault_dir,
   output logic       flash_red
);

   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam int WW = $clog2(WDOG_TICKS + 1);

   mon_state_t      state, state_nx;
   logic [2:0]      code_nx;
   logic [1:0]      dir_nx;
   logic            flash_nx;

   logic [3:0][2:0] lights;
   logic [3:0]      nonred, inv, skip, shrt;
   logic [12:0]     sample;
   logic [FW-1:0]   conf_cnt, ped_cnt, inv_cnt;
   logic [WW-1:0]   wd_cnt;

   logic run, clr_ok, all_red_idle, changed;
   logic conflict, ped_conf, inv_any;
   logic conf_hit, ped_hit, inv_hit, wd_hit;

   assign lights = {light_west, light_south, light_east, light_north};

   always_comb begin
      nonred = '0;
      for (int i = 0; i < 4; i++)
         nonred[i] = (lights[i] != RED);
   end

   assign run          = (state == MONITOR);
   assign all_red_idle = (nonred == 4'b0000) && !ped_walk;
   assign clr_ok       = (state == FAULT) && fault_clr && all_red_idle;
   assign changed      = ({lights, ped_walk} != sample);

   // More than one bit set: clearing the lowest set bit leaves something.
   assign conflict = ((nonred & (nonred - 4'd1)) != 4'b0000);
   assign ped_conf = ped_walk && (nonred != 4'b0000);
   assign inv_any  = (inv != 4'b0000);

   for (genvar i = 0; i < 4; i++) begin : g_app
      approach_seq_checker #(
         .MIN_YELLOW (MIN_YELLOW)
      ) u_chk (
         .clk          (clk),
         .rst_n        (rst_n),
         .tick         (tick),
         .light        (lights[i]),
         .freeze       (!run),
         .load         (clr_ok),
         .invalid      (inv[i]),
         .skip_yellow  (skip[i]),
         .short_yellow (shrt[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conf_cnt <= '0;
         ped_cnt  <= '0;
         inv_cnt  <= '0;
         wd_cnt   <= '0;
         sample   <= {RED, RED, RED, RED, 1'b0};
      end else if (clr_ok) begin
         conf_cnt <= '0;
         ped_cnt  <= '0;
         inv_cnt  <= '0;
         wd_cnt   <= '0;
         sample   <= {lights, ped_walk};
      end else if (run) begin
         conf_cnt <= conflict ? conf_cnt + 1'b1 : '0;
         ped_cnt  <= ped_conf ? ped_cnt + 1'b1 : '0;
         inv_cnt  <= inv_any ? inv_cnt + 1'b1 : '0;
         sample   <= {lights, ped_walk};
         if (changed || all_red_idle)
            wd_cnt <= '0;
         else if (tick)
            wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign conf_hit = conflict && (conf_cnt == FW'(FILTER_CYCLES - 1));
   assign ped_hit  = ped_conf && (ped_cnt == FW'(FILTER_CYCLES - 1));
   assign inv_hit  = inv_any && (inv_cnt == FW'(FILTER_CYCLES - 1));
   assign wd_hit   = tick && !changed && !all_red_idle
                     && (wd_cnt == WW'(WDOG_TICKS - 1));

   always_comb begin
      state_nx = state;
      code_nx  = fault_code;
      dir_nx   = fault_dir;
      flash_nx = flash_red;
      case (state)
         MONITOR: begin
            flash_nx = 1'b0;
            if (conf_hit) begin
               state_nx = FAULT;
               code_nx  = FC_CONFLICT;
               dir_nx   = DIR_N;
            end else if (ped_hit) begin
               state_nx = FAULT;
               code_nx  = FC_PED;
               dir_nx   = DIR_N;
            end else if (inv_hit) begin
               state_nx = FAULT;
               code_nx  = FC_INVALID;
               dir_nx   = low_idx(inv);
            end else if (skip != 4'b0000) begin
               state_nx = FAULT;
               code_nx  = FC_SKIP_YEL;
               dir_nx   = low_idx(skip);
            end else if (shrt != 4'b0000) begin
               state_nx = FAULT;
               code_nx  = FC_SHORT_YEL;
               dir_nx   = low_idx(shrt);
            end else if (wd_hit) begin
               state_nx = FAULT;
               code_nx  = FC_WDOG;
               dir_nx   = DIR_N;
            end
         end
         FAULT: begin
            if (clr_ok) begin
               state_nx = MONITOR;
               code_nx  = FC_NONE;
               dir_nx   = DIR_N;
               flash_nx = 1'b0;
            end else if (tick) begin
               flash_nx = !flash_red;
            end
         end
         default: state_nx = MONITOR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= MONITOR;
         fault_code <= FC_NONE;
         fault_dir  <= DIR_N;
         flash_red  <= 1'b0;
      end else begin
         state      <= state_nx;
         fault_code <= code_nx;
         fault_dir  <= dir_nx;
         flash_red  <= flash_nx;
      end
   end

   assign fault = (state == FAULT);

endmodule
